// File: rtl/video_mixer_pkg.sv
// Shared video constants: pixel format, display geometry, transparency code
// and the blink FSM state encoding used by the mixer.
package video_mixer_pkg;

  localparam int PIXEL_W     = 8;   // RRRGGGBB
  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int FRAME_CNT_W = 6;   // blink frame counter width (1-63 frames)

  localparam logic [PIXEL_W-1:0] TRANSPARENT_CODE = 8'h00;
  localparam logic [PIXEL_W-1:0] BLACK            = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HIDE = 2'd2
  } blink_state_e;

  // A layer pixel is drawn only when it differs from the see-through code.
  function automatic logic is_opaque(input logic [PIXEL_W-1:0] px,
                                     input logic [PIXEL_W-1:0] see_through);
    return px != see_through;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// N-deep single-bit shift register with a configurable reset value; used to
// line timing and control signals up with ROM-delayed pixel data.
module sync_delay #(
  parameter int   N       = 1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] stage_q;

  generate
    if (N == 1) begin : g_single
      // Single stage: plain register.
      always_ff @(posedge clk) begin
        if (reset) stage_q <= RST_VAL;
        else       stage_q <= d;
      end
    end else begin : g_chain
      // Multi-stage: shift towards the MSB, MSB is the oldest sample.
      always_ff @(posedge clk) begin
        if (reset) stage_q <= {N{RST_VAL}};
        else       stage_q <= {stage_q[N-2:0], d};
      end
    end
  endgenerate

  assign q = stage_q[N-1];

endmodule

// File: rtl/video_mixer.sv
// Three-layer VGA compositor (maze, player icon, success splash) with a
// frame-counted blink FSM that gates the splash after the game is won.
module video_mixer
  import video_mixer_pkg::*;
#(
  parameter int                 ROM_LAT     = 1,
  parameter logic [PIXEL_W-1:0] TRANSPARENT = TRANSPARENT_CODE,
  parameter int                 BLINK_ON    = 32,
  parameter int                 BLINK_OFF   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               video_on_in,
  input  logic               gameover,
  input  logic [PIXEL_W-1:0] bg_pixel,
  input  logic [PIXEL_W-1:0] icon_pixel,
  input  logic [PIXEL_W-1:0] splash_pixel,
  output logic               splash_en,
  output logic [PIXEL_W-1:0] rgb,
  output logic               hsync,
  output logic               vsync
);

  localparam logic [FRAME_CNT_W-1:0] ON_LAST  = FRAME_CNT_W'(BLINK_ON - 1);
  localparam logic [FRAME_CNT_W-1:0] OFF_LAST = FRAME_CNT_W'(BLINK_OFF - 1);

  // Delay-line lanes: 0=hsync, 1=vsync, 2=video_on, 3=splash_en.
  localparam logic [3:0] DLY_RST = 4'b0011;

  blink_state_e             state_q;
  logic [FRAME_CNT_W-1:0]   frame_cnt_q;
  logic                     splash_en_q;
  logic                     vsync_prev_q;
  logic                     frame_tick;
  logic [3:0]               dly_in;
  logic [3:0]               dly_out;
  logic [PIXEL_W-1:0]       rgb_d;
  logic [PIXEL_W-1:0]       rgb_q;
  logic                     hsync_q;
  logic                     vsync_q;

  // Registered vsync copy; the rising edge marks the end of the sync pulse.
  always_ff @(posedge clk) begin
    if (reset) vsync_prev_q <= 1'b1;
    else       vsync_prev_q <= vsync_in;
  end

  assign frame_tick = vsync_in & ~vsync_prev_q;

  // Blink FSM: only reacts at frame boundaries so the splash never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      splash_en_q <= 1'b0;
    end else if (frame_tick) begin
      if (!gameover) begin
        // Losing the win condition overrides any pending SHOW/HIDE change.
        state_q     <= IDLE;
        frame_cnt_q <= '0;
        splash_en_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q     <= SHOW;
            frame_cnt_q <= '0;
            splash_en_q <= 1'b1;
          end
          SHOW: begin
            if (frame_cnt_q == ON_LAST) begin
              state_q     <= HIDE;
              frame_cnt_q <= '0;
              splash_en_q <= 1'b0;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
              splash_en_q <= 1'b1;
            end
          end
          HIDE: begin
            if (frame_cnt_q == OFF_LAST) begin
              state_q     <= SHOW;
              frame_cnt_q <= '0;
              splash_en_q <= 1'b1;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
              splash_en_q <= 1'b0;
            end
          end
          default: begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            splash_en_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dly_in = {splash_en_q, video_on_in, vsync_in, hsync_in};

  // Align timing and splash gating with the ROM read latency.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dly
      sync_delay #(
        .N      (ROM_LAT),
        .RST_VAL(DLY_RST[gi])
      ) u_sync_delay (
        .clk  (clk),
        .reset(reset),
        .d    (dly_in[gi]),
        .q    (dly_out[gi])
      );
    end
  endgenerate

  // Layer priority: splash over icon over maze, black outside the visible area.
  always_comb begin
    rgb_d = BLACK;
    if (dly_out[2]) begin
      if (dly_out[3] && is_opaque(splash_pixel, TRANSPARENT)) rgb_d = splash_pixel;
      else if (is_opaque(icon_pixel, TRANSPARENT))           rgb_d = icon_pixel;
      else                                                    rgb_d = bg_pixel;
    end
  end

  // Final output register shared by pixel and sync outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q   <= BLACK;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= dly_out[0];
      vsync_q <= dly_out[1];
    end
  end

  assign splash_en = splash_en_q;
  assign rgb       = rgb_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;

endmodule

// File: tb/tb_video_mixer.sv
// Bench for video_mixer: four instances (ROM_LAT 1..4) share one stimulus.
// A frame-level reference model predicts every output each cycle; directed
// literal checks pin latency, layer priority, blink timing and reset.
module tb_video_mixer;

  localparam int NI   = 4;
  localparam int FL   = 24;
  localparam int ON   = 32;
  localparam int OFF  = 16;
  localparam int MAXC = 16384;

  logic       clk = 1'b0;
  logic       reset, hsync_in, vsync_in, video_on_in, gameover;
  logic [7:0] bg_pixel, icon_pixel, splash_pixel;
  logic [NI-1:0] se_o, hs_o, vs_o;
  logic [7:0] rgb_o [NI];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      video_mixer #(.ROM_LAT(gi + 1)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .video_on_in (video_on_in),
        .gameover    (gameover),
        .bg_pixel    (bg_pixel),
        .icon_pixel  (icon_pixel),
        .splash_pixel(splash_pixel),
        .splash_en   (se_o[gi]),
        .rgb         (rgb_o[gi]),
        .hsync       (hs_o[gi]),
        .vsync       (vs_o[gi])
      );
    end
  endgenerate

  // ---------------- reference model ----------------
  bit hs_s [MAXC];
  bit vs_s [MAXC];
  bit von_s[MAXC];
  bit spl_exp[MAXC];
  int k        = 0;
  int last_rst = -1000;
  bit started  = 0;
  bit act      = 0;   // win sequence running
  int pos      = 0;   // frames since the splash sequence started

  task automatic cmp(input string nm, input int inst, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s inst%0d cycle %0d: got %0h want %0h", nm, inst, k, a, e);
    end
  endtask

  task automatic lit(input string nm, input int inst, input logic [31:0] a, input logic [31:0] e);
    cmp(nm, inst, a, e);
    $display("check %s inst%0d cycle %0d: got %0h want %0h", nm, inst, k, a, e);
  endtask

  // Per-cycle predictor and comparator for all instances.
  always @(posedge clk) begin
    logic [7:0] bgv, icv, spv, exp_rgb;
    bit vprev, hs_e, vs_e, von_e, se_e;
    int src;
    k = k + 1;
    if (k >= MAXC - 1) begin
      $display("FAIL cycle_budget inst0 cycle %0d: got %0d want <%0d", k, k, MAXC - 1);
      $fatal(1, "cycle budget exhausted");
    end
    hs_s[k]  = hsync_in;
    vs_s[k]  = vsync_in;
    von_s[k] = video_on_in;
    bgv = bg_pixel; icv = icon_pixel; spv = splash_pixel;
    if (reset) begin
      last_rst   = k;
      started    = 1;
      act        = 0;
      pos        = 0;
      spl_exp[k] = 0;
    end else if (started) begin
      vprev = (k - 1 <= last_rst) ? 1'b1 : vs_s[k-1];
      if (vsync_in && !vprev) begin
        if (!gameover)  act = 0;
        else if (!act) begin act = 1; pos = 0; end
        else            pos = pos + 1;
      end
      spl_exp[k] = act && ((pos % (ON + OFF)) < ON);
    end
    #1;
    if (started) begin
      for (int i = 0; i < NI; i++) begin
        src = k - (i + 1);
        if (src > last_rst) begin
          hs_e = hs_s[src]; vs_e = vs_s[src]; von_e = von_s[src]; se_e = spl_exp[src-1];
        end else begin
          hs_e = 1; vs_e = 1; von_e = 0; se_e = 0;
        end
        if (!von_e)                 exp_rgb = 8'h00;
        else if (se_e && spv != 0)  exp_rgb = spv;
        else if (icv != 0)          exp_rgb = icv;
        else                        exp_rgb = bgv;
        cmp("m_splash_en", i, 32'(se_o[i]), 32'(spl_exp[k]));
        cmp("m_hsync",     i, 32'(hs_o[i]), 32'(hs_e));
        cmp("m_vsync",     i, 32'(vs_o[i]), 32'(vs_e));
        cmp("m_rgb",       i, 32'(rgb_o[i]), 32'(exp_rgb));
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [7:0] rpix();
    if ($urandom_range(0, 2) == 0) return 8'h00;
    return 8'($urandom);
  endfunction

  task automatic drv(input bit r, h, v, von, go, input logic [7:0] b, ic, sp);
    @(negedge clk);
    reset = r; hsync_in = h; vsync_in = v; video_on_in = von; gameover = go;
    bg_pixel = b; icon_pixel = ic; splash_pixel = sp;
  endtask

  // One frame: vsync low for two cycles, rising at cycle 2 (frame_tick).
  task automatic frame(input bit go_tick, go_rest, rnd, chk_rise, input int rst_at);
    for (int i = 0; i < FL; i++) begin
      bit g;
      g = (i <= 2) ? go_tick : go_rest;
      if (rnd && i > 4 && $urandom_range(0, 5) == 0) g = !g;
      drv(i == rst_at, (i % 8) != 0, i >= 2, (i >= 4) && (i < 20), g, rpix(), rpix(), rpix());
      if (chk_rise && i == 2) begin
        lit("rise_pre", 0, 32'(se_o[0]), 0);
        @(posedge clk); #1;
        lit("rise_1cyc", 0, 32'(se_o[0]), 1);
      end
      if (i == rst_at) begin
        @(posedge clk); #1;
        for (int j = 0; j < NI; j++) begin
          lit("rst_splash", j, 32'(se_o[j]), 0);
          lit("rst_rgb",    j, 32'(rgb_o[j]), 0);
          lit("rst_hsync",  j, 32'(hs_o[j]), 1);
          lit("rst_vsync",  j, 32'(vs_o[j]), 1);
        end
      end
    end
  endtask

  task automatic mux(input logic [7:0] b, ic, sp, input bit von, input logic [7:0] e);
    repeat (6) drv(0, 1, 1, von, 1, b, ic, sp);
    for (int j = 0; j < NI; j++) lit("mux_rgb", j, 32'(rgb_o[j]), 32'(e));
  endtask

  initial begin
    reset = 1; hsync_in = 1; vsync_in = 1; video_on_in = 0; gameover = 0;
    bg_pixel = 0; icon_pixel = 0; splash_pixel = 0;
    repeat (3) drv(1, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    @(posedge clk); #1;
    for (int j = 0; j < NI; j++) begin
      lit("reset_splash", j, 32'(se_o[j]), 0);
      lit("reset_rgb",    j, 32'(rgb_o[j]), 0);
      lit("reset_hsync",  j, 32'(hs_o[j]), 1);
      lit("reset_vsync",  j, 32'(vs_o[j]), 1);
    end

    // hsync pulse plus visible maze pixel one cycle later (ROM_LAT=1 instance)
    repeat (4) drv(0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    drv(0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00);
    drv(0, 1, 1, 0, 0, 8'hE0, 8'h00, 8'h00);
    @(posedge clk); #1;
    lit("lat_hsync", 0, 32'(hs_o[0]), 0);
    lit("lat_rgb",   0, 32'(rgb_o[0]), 32'h0E0);

    // Latency sweep: first cycle each instance shows the pulse
    for (int i = 0; i < NI; i++) begin
      int dh, dr;
      dh = -1; dr = -1;
      repeat (6) drv(0, 1, 1, 0, 0, 8'hE0, 8'h00, 8'h00);
      drv(0, 0, 1, 1, 0, 8'hE0, 8'h00, 8'h00);
      for (int d = 1; d <= 8; d++) begin
        @(posedge clk); #1;
        if (dh < 0 && hs_o[i] == 1'b0)  dh = d;
        if (dr < 0 && rgb_o[i] == 8'hE0) dr = d;
        drv(0, 1, 1, 0, 0, 8'hE0, 8'h00, 8'h00);
      end
      lit("sweep_hsync_lat", i, 32'(dh), 32'(i + 2));
      lit("sweep_rgb_lat",   i, 32'(dr), 32'(i + 2));
    end

    // Blink: gameover raised mid-frame, 32 frames on, 16 off, on again
    frame(0, 0, 0, 0, -1);
    frame(0, 1, 0, 0, -1);
    for (int f = 0; f <= 48; f++) begin
      frame(1, 1, 0, f == 0, -1);
      lit("blink", f, 32'(se_o[0]), 32'((f < 32) || (f >= 48)));
    end

    // Layer priority while splash is enabled
    mux(8'h1C, 8'h03, 8'hFF, 1, 8'hFF);
    mux(8'h1C, 8'h03, 8'h00, 1, 8'h03);
    mux(8'h1C, 8'h00, 8'h00, 1, 8'h1C);
    mux(8'h1C, 8'h03, 8'hFF, 0, 8'h00);

    // Back to idle, then drop gameover during HIDE frame 40
    frame(1, 0, 0, 0, -1);
    frame(0, 0, 0, 0, -1);
    lit("idle", 0, 32'(se_o[0]), 0);
    frame(0, 1, 0, 0, -1);
    for (int f = 0; f <= 40; f++) begin
      frame(1, (f == 40) ? 1'b0 : 1'b1, 0, 0, -1);
      lit("blink2", f, 32'(se_o[0]), 32'(f < 32));
    end
    frame(0, 1, 0, 0, -1);
    lit("drop_idle", 0, 32'(se_o[0]), 0);
    for (int f = 0; f <= 32; f++) begin
      frame(1, 1, 0, 0, -1);
      lit("regain", f, 32'(se_o[0]), 32'(f < 32));
    end

    // Reset during SHOW frame 20 with gameover held
    frame(1, 0, 0, 0, -1);
    frame(0, 1, 0, 0, -1);
    for (int f = 0; f < 20; f++) frame(1, 1, 0, 0, -1);
    frame(1, 1, 0, 0, 10);
    lit("post_reset_idle", 0, 32'(se_o[0]), 0);
    for (int f = 0; f < 3; f++) begin
      frame(1, 1, 0, 0, -1);
      lit("post_reset_show", f, 32'(se_o[0]), 1);
    end

    // Randomized frames: mid-frame gameover glitches and occasional resets
    for (int f = 0; f < 80; f++) begin
      bit gt, gr;
      int ra;
      gt = ($urandom_range(0, 15) != 0);
      gr = ($urandom_range(0, 15) != 0);
      ra = ($urandom_range(0, 29) == 0) ? int'($urandom_range(3, 20)) : -1;
      frame(gt, gr, 1, 0, ra);
    end

    repeat (8) drv(0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    @(posedge clk); #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
